// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
// Op codes, FSM states and default sizing.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

   typedef enum logic [1:0] {
      OP_MULU = 2'b00,
      OP_MUL  = 2'b01,
      OP_DIVU = 2'b10,
      OP_DIV  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// mdu_abs_neg: conditional two's-complement negate.
// Used for operand magnitudes and result sign fix-up.
module mdu_abs_neg #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply / restoring divide.
// One bit per cycle, Start/Busy/Done handshake, Hi/Lo result.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH);

   state_e           state;
   state_e           state_n;
   logic [CW-1:0]    cnt;
   op_e              op_q;
   logic             sa;
   logic             sb;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] p_lo;

   op_e              op_in;
   logic             in_sgn;
   logic             in_div;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic             is_div;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic             div_ok;
   logic [WIDTH-1:0] div_rem;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic               div_zero;

   assign op_in  = op_e'(Op);
   assign in_sgn = (op_in == OP_MUL) || (op_in == OP_DIV);
   assign in_div = (op_in == OP_DIVU) || (op_in == OP_DIV);
   assign a_neg  = in_sgn & A[WIDTH-1];
   assign b_neg  = in_sgn & B[WIDTH-1];

   mdu_abs_neg #(.W(WIDTH)) u_abs_a (
      .neg (a_neg),
      .x   (A),
      .y   (a_mag)
   );

   mdu_abs_neg #(.W(WIDTH)) u_abs_b (
      .neg (b_neg),
      .x   (B),
      .y   (b_mag)
   );

   assign is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);

   // Shift-add: add multiplicand to upper half when the
   // multiplier LSB (held in p_lo) is set, then shift right.
   assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);

   // Restoring step: shift remainder left, trial-subtract.
   // Low bits of the difference are exact when it is >= 0.
   assign div_sh  = {p_hi, p_lo[WIDTH-1]};
   assign div_ok  = (div_sh >= {1'b0, m});
   assign div_rem = div_sh[WIDTH-1:0] - m;

   mdu_abs_neg #(.W(2*WIDTH)) u_fix_prod (
      .neg (sa ^ sb),
      .x   ({p_hi, p_lo}),
      .y   (prod_fix)
   );

   mdu_abs_neg #(.W(WIDTH)) u_fix_quo (
      .neg (sa ^ sb),
      .x   (p_lo),
      .y   (quo_fix)
   );

   mdu_abs_neg #(.W(WIDTH)) u_fix_rem (
      .neg (sa),
      .x   (p_hi),
      .y   (rem_fix)
   );

   assign div_zero = (m == '0);
   assign Busy     = (state != S_IDLE);

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next-state: IDLE -> RUN on Start, WIDTH iterations, FIX.
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (Start) state_n = S_RUN;
         S_RUN:   if (cnt == CW'(WIDTH-1)) state_n = S_FIX;
         S_FIX:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath: operand latch, per-cycle iteration, result fix-up.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt       <= '0;
         op_q      <= OP_MULU;
         sa        <= 1'b0;
         sb        <= 1'b0;
         m         <= '0;
         p_hi      <= '0;
         p_lo      <= '0;
         Hi        <= '0;
         Lo        <= '0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         Done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (Start) begin
                  op_q      <= op_in;
                  sa        <= a_neg;
                  sb        <= b_neg;
                  m         <= in_div ? b_mag : a_mag;
                  p_lo      <= in_div ? a_mag : b_mag;
                  p_hi      <= '0;
                  cnt       <= '0;
                  DivByZero <= 1'b0;
               end
            end
            S_RUN: begin
               cnt <= cnt + CW'(1);
               if (is_div) begin
                  p_hi <= div_ok ? div_rem : div_sh[WIDTH-1:0];
                  p_lo <= {p_lo[WIDTH-2:0], div_ok};
               end else begin
                  p_hi <= mul_sum[WIDTH:1];
                  p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               Done <= 1'b1;
               if (is_div) begin
                  Hi        <= rem_fix;
                  Lo        <= div_zero ? '1 : quo_fix;
                  DivByZero <= div_zero;
               end else begin
                  Hi <= prod_fix[2*WIDTH-1:WIDTH];
                  Lo <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: vector table plus scoreboard checks
// of mul_div_unit results, latency and handshake corners.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         Start;
   logic [1:0]   Op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Hi;
   logic [W-1:0] Lo;
   logic         DivByZero;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[16];

   int n_vec = 0;
   int n_bad = 0;
   int cyc_g = 0;
   int last_done = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .Op        (Op),
      .A         (A),
      .B         (B),
      .Busy      (Busy),
      .Done      (Done),
      .Hi        (Hi),
      .Lo        (Lo),
      .DivByZero (DivByZero)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc_g <= cyc_g + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hi, input logic [31:0] lo,
                               input logic dz);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
      return v;
   endfunction

   function automatic vec_t model(input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      vec_t v;
      v = mk(op, a, b, 32'h0, 32'h0, 1'b0);
      case (op)
         2'b00: begin
            p = {32'h0, a} * {32'h0, b};
            v.hi = p[63:32]; v.lo = p[31:0];
         end
         2'b01: begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            v.hi = p[63:32]; v.lo = p[31:0];
         end
         2'b10: begin
            if (b == 0) begin
               v.lo = 32'hFFFFFFFF; v.hi = a; v.dz = 1'b1;
            end else begin
               v.lo = a / b; v.hi = a % b;
            end
         end
         default: begin
            if (b == 0) begin
               v.lo = 32'hFFFFFFFF; v.hi = a; v.dz = 1'b1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               v.lo = 32'h80000000; v.hi = 32'h0;
            end else begin
               v.lo = $signed(a) / $signed(b);
               v.hi = $signed(a) % $signed(b);
            end
         end
      endcase
      return v;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int cyc;
      int busy_n;
      bit both;
      bit got;
      vec_t e;
      Op = v.op; A = v.a; B = v.b; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      sb.push_back(v);
      chk({tag, " dz_clear"}, {63'h0, DivByZero}, 64'h0);
      cyc = 0; busy_n = 0; both = 0; got = 0;
      while (!got && cyc < 100) begin
         if (Busy) busy_n++;
         if (Busy && Done) both = 1;
         if (Done) got = 1;
         else begin
            @(posedge Clk); #1;
            cyc++;
         end
      end
      e = sb.pop_front();
      if (!got) begin
         chk({tag, " timeout"}, 64'h0, 64'h1);
      end else begin
         last_done = cyc_g;
         chk({tag, " latency"}, 64'(cyc), 64'd33);
         chk({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
         chk({tag, " busy_done"}, {63'h0, both}, 64'h0);
         chk({tag, " hi"}, {32'h0, Hi}, {32'h0, e.hi});
         chk({tag, " lo"}, {32'h0, Lo}, {32'h0, e.lo});
         chk({tag, " dz"}, {63'h0, DivByZero}, {63'h0, e.dz});
      end
   endtask

   task automatic ignore_test();
      vec_t v;
      vec_t e;
      int cyc;
      int dones;
      int dcyc;
      logic [31:0] hi_s;
      logic [31:0] lo_s;
      v = mk(2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);
      Op = v.op; A = v.a; B = v.b; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      sb.push_back(v);
      Op = 2'b10; A = 32'd99; B = 32'd7;
      cyc = 0; dones = 0; dcyc = -1; hi_s = '0; lo_s = '0;
      while (cyc < 80) begin
         if (Done) begin
            dones++; dcyc = cyc; hi_s = Hi; lo_s = Lo;
         end
         Start = (cyc == 5 || cyc == 20 || cyc == 32);
         @(posedge Clk); #1;
         cyc++;
      end
      Start = 1'b0;
      e = sb.pop_front();
      chk("ign done_count", 64'(dones), 64'd1);
      chk("ign done_cyc", 64'(dcyc), 64'd33);
      chk("ign hi", {32'h0, hi_s}, {32'h0, e.hi});
      chk("ign lo", {32'h0, lo_s}, {32'h0, e.lo});
      chk("ign idle", {63'h0, Busy}, 64'h0);
   endtask

   initial begin
      int d1;
      int dones;
      int busy_seen;
      logic [1:0] rop;
      logic [31:0] ra;
      logic [31:0] rb;

      Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst busy", {63'h0, Busy}, 64'h0);
      chk("rst done", {63'h0, Done}, 64'h0);
      chk("rst hi", {32'h0, Hi}, 64'h0);
      chk("rst lo", {32'h0, Lo}, 64'h0);
      chk("rst dz", {63'h0, DivByZero}, 64'h0);
      Rst = 1'b0;
      @(posedge Clk); #1;

      tbl[0]  = mk(2'b00, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0);
      tbl[1]  = mk(2'b01, 32'hFFFFFFFD, 32'd5,
                   32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      tbl[2]  = mk(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001, 1'b0);
      tbl[3]  = mk(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      tbl[4]  = mk(2'b11, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      tbl[5]  = mk(2'b11, 32'h80000000, 32'hFFFFFFFF,
                   32'h0, 32'h80000000, 1'b0);
      tbl[6]  = mk(2'b10, 32'h1234, 32'h0,
                   32'h1234, 32'hFFFFFFFF, 1'b1);
      tbl[7]  = mk(2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);
      tbl[8]  = mk(2'b11, 32'hFFFFFFF9, 32'h0,
                   32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
      tbl[9]  = mk(2'b11, 32'd100, 32'hFFFFFFF9,
                   32'd2, 32'hFFFFFFF2, 1'b0);
      tbl[10] = mk(2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9,
                   32'hFFFFFFFE, 32'd14, 1'b0);
      tbl[11] = mk(2'b01, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h0, 1'b0);
      tbl[12] = mk(2'b01, 32'hFFFFFFFF, 32'h80000000,
                   32'h0, 32'h80000000, 1'b0);
      tbl[13] = mk(2'b10, 32'hFFFFFFFF, 32'd1,
                   32'h0, 32'hFFFFFFFF, 1'b0);
      tbl[14] = mk(2'b10, 32'd5, 32'd9, 32'd5, 32'h0, 1'b0);
      tbl[15] = mk(2'b00, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         run_op(tbl[i], $sformatf("tbl%0d", i));
      end

      for (int i = 0; i < 12; i++) begin
         rop = 2'(i % 4);
         ra  = $urandom;
         rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op(model(rop, ra, rb), $sformatf("rnd%0d", i));
      end

      run_op(tbl[0], "b2b_a");
      d1 = last_done;
      run_op(tbl[3], "b2b_b");
      chk("b2b spacing", 64'(last_done - d1), 64'd34);

      ignore_test();

      Op = 2'b10; A = 32'd100; B = 32'd7; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (10) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("abort busy", {63'h0, Busy}, 64'h0);
      chk("abort done", {63'h0, Done}, 64'h0);
      chk("abort hi", {32'h0, Hi}, 64'h0);
      chk("abort lo", {32'h0, Lo}, 64'h0);
      Rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge Clk); #1;
         if (Done) dones++;
      end
      chk("abort no_done", 64'(dones), 64'd0);

      Op = 2'b00; A = 32'd5; B = 32'd5;
      Start = 1'b1; Rst = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0; Rst = 1'b0;
      dones = 0; busy_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (Busy) busy_seen++;
         if (Done) dones++;
         @(posedge Clk); #1;
      end
      chk("rst_start busy", 64'(busy_seen), 64'd0);
      chk("rst_start done", 64'(dones), 64'd0);

      run_op(tbl[1], "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
